// File: rtl/pulse_pwm.sv
// -----------------------------------------------------------------------------
// pulse_pwm
//   Tick-driven PWM generator. Each frame lasts act_period+1 ticks and pwm is
//   high for the first act_duty ticks of the frame. period/duty are captured
//   into shadow registers by 'load' and only become active on a frame
//   boundary (or on entry from IDLE). Dropping 'enable' lets the current frame
//   finish before the block returns to IDLE.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous, active-high reset
//   tick       in   timebase enable (one counter step per tick)
//   enable     in   1 = run, 0 = finish current frame then idle
//   period     in   [WIDTH] frame length minus 1, in ticks
//   duty       in   [WIDTH] high time per frame, in ticks
//   load       in   strobe: capture period/duty into the shadow registers
//   pwm        out  PWM output, decoded from registers only
//   frame_end  out  one-cycle strobe in the cycle after a frame wrap
//   pending    out  shadow registers hold values not yet applied
// -----------------------------------------------------------------------------
module pulse_pwm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             enable,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] duty,
  input  logic             load,
  output logic             pwm,
  output logic             frame_end,
  output logic             pending
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] act_period_q, act_period_d;
  logic [WIDTH-1:0] act_duty_q, act_duty_d;
  logic [WIDTH-1:0] sh_period_q, sh_period_d;
  logic [WIDTH-1:0] sh_duty_q, sh_duty_d;
  logic             pending_q, pending_d;
  logic             frame_end_q, frame_end_d;
  logic             wrap;

  // A tick with the counter at the active period ends the frame. Because the
  // counter wraps exactly at act_period it can never exceed it, so there is
  // no overflow case even at period = 2^WIDTH-1.
  assign wrap = (state_q != IDLE) && tick && (cnt_q == act_period_q);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned;
    // otherwise synthesis infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    act_period_d = act_period_q;
    act_duty_d   = act_duty_q;
    sh_period_d  = sh_period_q;
    sh_duty_d    = sh_duty_q;
    pending_d    = pending_q;
    frame_end_d  = 1'b0;

    // Last load wins in the shadow; whether it also becomes pending depends
    // on whether it lands on an activation point (handled below).
    if (load) begin
      sh_period_d = period;
      sh_duty_d   = duty;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (load) pending_d = 1'b1;
        if (enable) begin
          state_d = RUN;
          // A load coinciding with entry is used directly.
          if (load) begin
            act_period_d = period;
            act_duty_d   = duty;
            pending_d    = 1'b0;
          end else if (pending_q) begin
            act_period_d = sh_period_q;
            act_duty_d   = sh_duty_q;
            pending_d    = 1'b0;
          end
        end
      end

      RUN, DRAIN: begin
        if (wrap) begin
          cnt_d       = '0;
          frame_end_d = 1'b1;
          // A load on the boundary bypasses the shadow and never pends.
          if (load) begin
            act_period_d = period;
            act_duty_d   = duty;
            pending_d    = 1'b0;
          end else if (pending_q) begin
            act_period_d = sh_period_q;
            act_duty_d   = sh_duty_q;
            pending_d    = 1'b0;
          end
        end else begin
          if (tick) cnt_d = cnt_q + 1'b1;
          if (load) pending_d = 1'b1;
        end

        if (state_q == RUN) begin
          if (!enable) state_d = DRAIN;
        end else begin
          // Re-enable during the drain resumes without breaking the frame.
          if (enable)    state_d = RUN;
          else if (wrap) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; shadow registers are cleared too, so any
    // not-yet-applied load is discarded by reset.
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      act_period_q <= '0;
      act_duty_q   <= '0;
      sh_period_q  <= '0;
      sh_duty_q    <= '0;
      pending_q    <= 1'b0;
      frame_end_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      act_period_q <= act_period_d;
      act_duty_q   <= act_duty_d;
      sh_period_q  <= sh_period_d;
      sh_duty_q    <= sh_duty_d;
      pending_q    <= pending_d;
      frame_end_q  <= frame_end_d;
    end
  end

  assign pwm       = (state_q != IDLE) && (cnt_q < act_duty_q);
  assign frame_end = frame_end_q;
  assign pending   = pending_q;

endmodule
